// File: rtl/neg_sched_pkg.sv
// Shared definitions for the negation scheduler: FSM state encoding and default width.
package neg_sched_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/neg_sched_serial_neg.sv
// Bit-serial two's-complement negator: LSB-first, one bit per shift cycle.
module neg_sched_serial_neg
  import neg_sched_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_operand,
  output logic         o_last,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_op;
  logic [W-1:0]  r_res;
  logic          r_seen;
  logic [CW-1:0] r_cnt;
  logic          w_in_bit;
  logic          w_out_bit;

  assign w_in_bit  = r_op[0];
  assign w_out_bit = w_in_bit ^ r_seen;
  // Result value after the current bit lands; complete when o_last is high.
  assign o_result  = {w_out_bit, r_res[W-1:1]};
  assign o_last    = (r_cnt == CW'(W - 1));
  // At the MSB step: MSB set with no lower one seen means the most negative value.
  assign o_ovf     = w_in_bit & ~r_seen;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op   <= '0;
      r_res  <= '0;
      r_seen <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_op   <= i_operand;
      r_res  <= '0;
      r_seen <= 1'b0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_op   <= {1'b0, r_op[W-1:1]};
      r_res  <= o_result;
      r_seen <= r_seen | w_in_bit;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/neg_sched.sv
// Round-robin scheduler sharing one bit-serial negation engine between two requesters.
module neg_sched
  import neg_sched_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req0,
  input  logic [W-1:0] i_a0,
  input  logic         i_req1,
  input  logic [W-1:0] i_a1,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic [W-1:0] o_res,
  output logic         o_ovf,
  output logic         o_busy
);

  state_e       r_state;
  logic         r_ptr;
  logic         r_owner;
  logic         r_ack0;
  logic         r_ack1;
  logic [W-1:0] r_res;
  logic         r_ovf;

  logic         w_any;
  logic         w_pick;
  logic [W-1:0] w_operand;
  logic         w_load;
  logic         w_shift;
  logic         w_last;
  logic [W-1:0] w_result;
  logic         w_ovf;

  assign w_any     = i_req0 | i_req1;
  // Contention goes to whoever was not served last; a lone request always wins.
  assign w_pick    = (i_req0 & i_req1) ? ~r_ptr : i_req1;
  assign w_operand = w_pick ? i_a1 : i_a0;
  assign w_load    = (r_state == StIdle) & w_any;
  assign w_shift   = (r_state == StShift);

  neg_sched_serial_neg #(
    .W(W)
  ) u_engine (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_operand(w_operand),
    .o_last   (w_last),
    .o_result (w_result),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_ptr   <= 1'b1;
      r_owner <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_ptr   <= w_pick;
            r_state <= StShift;
          end
        end
        StShift: begin
          // Outputs are loaded on entry to DONE so they are valid alongside the ack.
          if (w_last) begin
            r_res   <= w_result;
            r_ovf   <= w_ovf;
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ack0 = r_ack0;
  assign o_ack1 = r_ack1;
  assign o_res  = r_res;
  assign o_ovf  = r_ovf;
  assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_neg_sched.sv
// Self-checking bench for neg_sched: directed scenarios then random traffic against a
// transaction-level model (arithmetic negation, round-robin winner, fixed latency).
module tb_neg_sched;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         req0;
  logic [W-1:0] a0;
  logic         req1;
  logic [W-1:0] a1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] res;
  logic         ovf;
  logic         busy;

  int           errors;
  int           checks;
  logic         last;
  logic [W-1:0] last_res;
  logic         last_ovf;

  neg_sched #(
    .W(W)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_req0 (req0),
    .i_a0   (a0),
    .i_req1 (req1),
    .i_a1   (a1),
    .o_ack0 (ack0),
    .o_ack1 (ack1),
    .o_res  (res),
    .o_ovf  (ovf),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One transaction: inputs are already driven and the DUT is idle before the next edge.
  task automatic txn(input bit scramble);
    logic         w;
    logic [W-1:0] x;
    logic [W-1:0] e;
    logic [W-1:0] minv;
    logic         eo;
    bit           seen;
    w    = (req0 && req1) ? ~last : req1;
    x    = w ? a1 : a0;
    e    = W'((32'd1 << W) - 32'(x));
    minv = '0;
    minv[W-1] = 1'b1;
    eo   = (x == minv);
    seen = 0;
    @(posedge clk);
    for (int k = 0; k <= W + 2 && !seen; k++) begin
      @(negedge clk);
      if (scramble && k == 1) begin
        a0 = W'($urandom);
        a1 = W'($urandom);
      end
      if (ack0 || ack1) begin
        seen = 1;
        chk("ack_latency", k, W);
        chk("ack_owner", {ack1, ack0}, w ? 2'b10 : 2'b01);
        chk("res", res, e);
        chk("ovf", ovf, eo);
        chk("busy_done", busy, 1);
        last     = w;
        last_res = e;
        last_ovf = eo;
      end else begin
        chk("busy_shift", busy, 1);
        chk("res_hold", res, last_res);
        chk("ovf_hold", ovf, last_ovf);
      end
    end
    checks++;
    assert (seen)
    else begin
      errors++;
      $error("FAIL ack_timeout: observed=no ack expected=ack within %0d cycles", W + 3);
    end
  endtask

  task automatic idle_step();
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ack_idle", {ack1, ack0}, 2'b00);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0;
    a1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_res", res, 0);
    chk("rst_ovf", ovf, 0);

    // Both requesters held from reset: strict alternation starting with requester 0.
    req0 = 1'b1; a0 = 4'd3;
    req1 = 1'b1; a1 = 4'd6;
    reset = 1'b0;
    txn(0);
    chk("rr_first", last, 0);
    idle_step();
    txn(0);
    chk("rr_second", last, 1);
    idle_step();
    txn(0);
    chk("rr_third", last, 0);
    req0 = 1'b0; req1 = 1'b0;
    idle_step();
    idle_step();

    // Directed single-requester operands, including the most negative value.
    req0 = 1'b1; a0 = 4'd5; txn(0); req0 = 1'b0; idle_step();
    req1 = 1'b1; a1 = 4'd0; txn(0); req1 = 1'b0; idle_step();
    req1 = 1'b1; a1 = 4'd1; txn(0); req1 = 1'b0; idle_step();
    req0 = 1'b1; a0 = 4'b1000; txn(0); req0 = 1'b0; idle_step();
    req0 = 1'b1; a0 = 4'b0111; txn(0); req0 = 1'b0; idle_step();
    req0 = 1'b1; a0 = 4'd9; txn(1); req0 = 1'b0; idle_step();

    // Reset two cycles into SHIFT aborts the operation.
    req0 = 1'b1; a0 = 4'd5;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_ack", {ack1, ack0}, 2'b00);
    chk("abort_busy", busy, 0);
    chk("abort_res", res, 0);
    chk("abort_ovf", ovf, 0);
    reset = 1'b0;
    last = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    req0 = 1'b1; a0 = 4'd2; txn(0); req0 = 1'b0; idle_step();

    // Random traffic; requests may stay high across acks.
    for (int i = 0; i < 60; i++) begin
      if (!req0 && !req1) begin
        int r;
        r = $urandom_range(1, 3);
        req0 = r[0];
        req1 = r[1];
        a0 = W'($urandom);
        a1 = W'($urandom);
      end
      txn(bit'($urandom_range(0, 1)));
      req0 = req0 & bit'($urandom_range(0, 1));
      req1 = req1 & bit'($urandom_range(0, 1));
      idle_step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
